// File: rtl/fp16_seq_divider.sv
// -----------------------------------------------------------------------------
// fp16_seq_divider
//
// Multi-cycle IEEE-754 half-precision divider: result = a_operand / b_operand.
// The mantissa quotient comes from a restoring shift-subtract loop that
// produces one quotient bit per clock. Rounding is truncation. Subnormal
// inputs are treated as zero. The operand, flag and result port names match
// the combinational FP16 multiplier, so the two blocks can be swapped.
//
// Timing: a start accepted in IDLE at clock edge 0 produces a one-cycle done
// pulse that is sampled high at edge 14. This holds for every operand class.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; aborts any division in flight
//   start      request, sampled only in IDLE
//   a_operand  dividend {sign, exp, man}, captured on an accepted start
//   b_operand  divisor, captured on an accepted start
//   busy       high from the cycle after an accepted start until done
//   done       one-cycle pulse when result and flags are valid
//   result     quotient, held until the next accepted start
//   Exception  divide-by-zero, or either operand has an all-ones exponent
//   Overflow   result exponent >= 31
//   Underflow  result exponent <= 0 (non-exception case)
// -----------------------------------------------------------------------------
module fp16_seq_divider #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BIAS  = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a_operand,
    input  logic [EXP_W+MAN_W:0]   b_operand,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   Exception,
    output logic                   Overflow,
    output logic                   Underflow
);

    localparam int W       = 1 + EXP_W + MAN_W;
    localparam int QW      = MAN_W + 2;          // quotient / remainder width
    localparam int CW      = $clog2(QW);         // iteration counter width
    localparam int XW      = EXP_W + 3;          // signed working exponent width
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    localparam logic signed [XW-1:0] BIAS_S = XW'(BIAS);
    localparam logic signed [XW-1:0] EMAX_S = XW'(EXP_MAX);
    localparam logic signed [XW-1:0] ONE_S  = XW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_NORM,
        S_DONE
    } state_t;

    // Control state
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    result_q, result_d;
    logic            exc_q, exc_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    // Datapath state (no reset needed: always written before use)
    logic [EXP_W:0]  a_hi_q, a_hi_d;   // dividend {sign, exp}; its mantissa lives in rem
    logic [W-1:0]    b_q, b_d;
    logic [QW-1:0]   rem_q, rem_d;
    logic [QW-1:0]   quo_q, quo_d;

    // Restoring step
    logic [QW-1:0]   mb;
    logic            ge;
    logic [QW-1:0]   diff;

    assign mb   = {1'b0, 1'b1, b_q[MAN_W-1:0]};
    assign ge   = (rem_q >= mb);
    assign diff = ge ? (rem_q - mb) : rem_q;

    // Normalisation and exception classification
    logic [EXP_W-1:0]        ea, eb;
    logic                    sgn;
    logic signed [XW-1:0]    exp_pre, exp_fin;
    logic [MAN_W-1:0]        man_n;
    logic [W-1:0]            norm_res;
    logic                    norm_exc, norm_ovf, norm_unf;

    assign ea  = a_hi_q[EXP_W-1:0];
    assign eb  = b_q[W-2 -: EXP_W];
    assign sgn = a_hi_q[EXP_W] ^ b_q[W-1];
    assign exp_pre = $signed({{(XW-EXP_W){1'b0}}, ea})
                   - $signed({{(XW-EXP_W){1'b0}}, eb}) + BIAS_S;

    always_comb begin
        // ma/mb lies in (0.5, 2), so the quotient's leading one is at bit QW-1
        // or QW-2; the second case needs a one-place shift and exponent decrement.
        if (quo_q[QW-1]) begin
            man_n   = quo_q[QW-2:1];
            exp_fin = exp_pre;
        end else begin
            man_n   = quo_q[MAN_W-1:0];
            exp_fin = exp_pre - ONE_S;
        end

        norm_exc = 1'b0;
        norm_ovf = 1'b0;
        norm_unf = 1'b0;
        norm_res = {sgn, exp_fin[EXP_W-1:0], man_n};

        if ((&ea) || (&eb) || (eb == '0)) begin
            norm_exc = 1'b1;
            norm_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (ea == '0) begin
            norm_res = {sgn, {(W-1){1'b0}}};
        end else if (exp_fin >= EMAX_S) begin
            norm_ovf = 1'b1;
            norm_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (exp_fin < ONE_S) begin
            norm_unf = 1'b1;
            norm_res = {sgn, {(W-1){1'b0}}};
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        exc_d    = exc_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        a_hi_d   = a_hi_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_hi_d  = a_operand[W-1:MAN_W];
                    b_d     = b_operand;
                    rem_d   = {1'b0, 1'b1, a_operand[MAN_W-1:0]};
                    quo_d   = '0;
                    cnt_d   = CW'(QW - 1);
                    exc_d   = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                // Shift the new quotient bit in from the right; after QW steps
                // the first bit decided sits at the MSB.
                quo_d = {quo_q[QW-2:0], ge};
                // After a subtract diff < mb < 2^(QW-1), so the shift never
                // loses a set bit.
                rem_d = {diff[QW-2:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_NORM: begin
                result_d = norm_res;
                exc_d    = norm_exc;
                ovf_d    = norm_ovf;
                unf_d    = norm_unf;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
        a_hi_q <= a_hi_d;
        b_q    <= b_d;
        rem_q  <= rem_d;
        quo_q  <= quo_d;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign Exception = exc_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

endmodule

// File: tb/tb_fp16_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_fp16_seq_divider
//
// Self-checking bench for fp16_seq_divider. A behavioural model tracks the
// handshake by counting edges since the last accepted start and computes the
// quotient with plain integer arithmetic; one compare process checks every
// output on every cycle. Directed operations pin latency and literal results,
// then a randomized back-to-back sweep exercises the arithmetic and the
// ignore-while-busy behaviour.
// -----------------------------------------------------------------------------
module tb_fp16_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a_operand = 16'h0;
    logic [15:0] b_operand = 16'h0;
    logic        busy, done, Exception, Overflow, Underflow;
    logic [15:0] result;

    always #5 clk = ~clk;

    fp16_seq_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_operand (a_operand),
        .b_operand (b_operand),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .Exception (Exception),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    int checks = 0;
    int errors = 0;
    int ndone  = 0;

    localparam int NOPS = 5000;

    // Reference: returns {Exception, Overflow, Underflow, result}
    function automatic logic [18:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        logic s;
        int   ea, eb, ma, mb, q, e, man;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        ma = 1024 + int'(a[9:0]);
        mb = 1024 + int'(b[9:0]);
        if (ea == 31 || eb == 31 || eb == 0) return {3'b100, s, 5'b11111, 10'd0};
        if (ea == 0) return {3'b000, s, 15'd0};
        q = (ma * 2048) / mb;
        e = ea - eb + 15;
        if (q >= 2048) begin
            man = (q / 2) % 1024;
        end else begin
            man = q % 1024;
            e   = e - 1;
        end
        if (e >= 31) return {3'b010, s, 5'b11111, 10'd0};
        if (e <= 0)  return {3'b001, s, 15'd0};
        return {3'b000, s, e[4:0], man[9:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
        end
    endtask

    // Behavioural model: age = edges since accepted start, -1 when idle.
    int          age  = -1;
    bit          live = 1'b0;
    logic [18:0] pend = '0;
    logic [18:0] held = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            live = 1'b1;
            age  = -1;
            held = '0;
        end else if (age < 0) begin
            if (start) begin
                age  = 0;
                pend = ref_div(a_operand, b_operand);
                held[18:16] = 3'b000;
            end
        end else begin
            age++;
            if (age == 13) held = pend;
            else if (age == 14) age = -1;
        end
    end

    logic [20:0] exp_v, got_v;

    always @(negedge clk) begin
        if (live) begin
            exp_v = {(age >= 0 && age <= 12), (age == 13), held};
            got_v = {busy, done, Exception, Overflow, Underflow, result};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_cmp got={busy,done,E,O,U,res}=%h want=%h t=%0t",
                         got_v, exp_v, $time);
            end
            if (done === 1'b1) ndone++;
        end
    end

    // Directed operation: checks latency and literal {E,O,U,result}.
    task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic [18:0] want);
        int n;
        @(negedge clk);
        start = 1'b1; a_operand = a; b_operand = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, n + 1, 14);
        chk({nm, "_res"}, {13'd0, Exception, Overflow, Underflow, result}, {13'd0, want});
    endtask

    function automatic logic [15:0] rnd_fp();
        logic [15:0] v;
        logic [4:0]  e;
        v = 16'($urandom);
        if ($urandom_range(0, 31) == 0) e = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31;
        else e = 5'($urandom_range(1, 30));
        v[14:10] = e;
        return v;
    endfunction

    initial begin
        #1500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;

        // Model pinning against hand-computed values
        chk("ref_6_div_2",   {13'd0, ref_div(16'h4600, 16'h4000)}, {13'd0, 3'b000, 16'h4200});
        chk("ref_1_div_3",   {13'd0, ref_div(16'h3C00, 16'h4200)}, {13'd0, 3'b000, 16'h3555});
        chk("ref_sign",      {13'd0, ref_div(16'hC900, 16'h4100)}, {13'd0, 3'b000, 16'hC400});
        chk("ref_ovf",       {13'd0, ref_div(16'h7BFF, 16'h1400)}, {13'd0, 3'b010, 16'h7C00});
        chk("ref_unf",       {13'd0, ref_div(16'h0400, 16'h4000)}, {13'd0, 3'b001, 16'h0000});
        chk("ref_divzero",   {13'd0, ref_div(16'h3C00, 16'h0000)}, {13'd0, 3'b100, 16'h7C00});

        // Reset held with start high: nothing may start
        rst_n = 1'b0; start = 1'b1; a_operand = 16'h4600; b_operand = 16'h4000;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", {10'd0, busy, done, Exception, Overflow, Underflow, result}, 32'd0);
        end
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);

        // Directed operations; each call's start lands in the cycle after the previous done
        run_op("basic",    16'h4600, 16'h4000, {3'b000, 16'h4200});
        run_op("trunc",    16'h3C00, 16'h4200, {3'b000, 16'h3555});
        run_op("sign",     16'hC900, 16'h4100, {3'b000, 16'hC400});
        run_op("overflow", 16'h7BFF, 16'h1400, {3'b010, 16'h7C00});
        run_op("underflow",16'h0400, 16'h4000, {3'b001, 16'h0000});
        run_op("divzero",  16'h3C00, 16'h0000, {3'b100, 16'h7C00});
        run_op("negzero",  16'hBC00, 16'h0000, {3'b100, 16'hFC00});
        run_op("inf_a",    16'h7C00, 16'h3C00, {3'b100, 16'h7C00});
        run_op("zero_a",   16'h0000, 16'h4000, {3'b000, 16'h0000});

        // Starts at cycles 5 and 13 of a division are ignored
        @(negedge clk);
        start = 1'b1; a_operand = 16'h4600; b_operand = 16'h4000;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            start = (n == 4 || n == 12);
            if (start) begin a_operand = 16'h3C00; b_operand = 16'h4200; end
        end
        start = 1'b0;
        chk("midstart_latency", n + 1, 14);
        chk("midstart_res", {13'd0, Exception, Overflow, Underflow, result}, {13'd0, 3'b000, 16'h4200});
        @(negedge clk);
        chk("midstart_idle", {31'd0, busy}, 32'd0);

        // Reset at cycle 7 aborts the division
        @(negedge clk);
        start = 1'b1; a_operand = 16'h3C00; b_operand = 16'h4200;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_outputs", {10'd0, busy, done, Exception, Overflow, Underflow, result}, 32'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);

        // Randomized back-to-back sweep: start held high, operands change every cycle
        begin
            int base;
            base = ndone;
            start = 1'b1;
            for (int i = 0; i < 15 * NOPS + 50 && ndone < base + NOPS; i++) begin
                @(negedge clk);
                a_operand = rnd_fp();
                b_operand = rnd_fp();
            end
            start = 1'b0;
            repeat (20) @(negedge clk);
            chk("random_done_count", ndone - base, NOPS);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
